// File: rtl/wb_pkg.sv
// Shared types for the Wishbone command master: FSM state and response status codes.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RESPOND = 2'd2
  } wb_master_state_t;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_ERR     = 2'd1,
    RSP_TIMEOUT = 2'd2
  } wb_rsp_status_t;

endpackage

// File: rtl/wb_master_cmd_if.sv
// Command/response handshake plus Wishbone B4 classic master bus for wb_master_cmd.
interface wb_master_cmd_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int GRANULE    = 8
);
  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;

  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_we_i;
  logic [ADDR_WIDTH-1:0] cmd_adr_i;
  logic [DATA_WIDTH-1:0] cmd_dat_i;
  logic [SEL_WIDTH-1:0]  cmd_sel_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_dat_o;
  logic [1:0]            rsp_status_o;

  logic [ADDR_WIDTH-1:0] adr_o;
  logic [DATA_WIDTH-1:0] dat_o;
  logic [SEL_WIDTH-1:0]  sel_o;
  logic                  we_o;
  logic                  stb_o;
  logic                  cyc_o;
  logic [DATA_WIDTH-1:0] dat_i;
  logic                  ack_i;
  logic                  err_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
    input  dat_i, ack_i, err_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
    output adr_o, dat_o, sel_o, we_o, stb_o, cyc_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
    output dat_i, ack_i, err_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
    input  adr_o, dat_o, sel_o, we_o, stb_o, cyc_o
  );

endinterface

// File: rtl/wb_master_cmd.sv
// Single-transaction Wishbone B4 classic master: one command in, one bus cycle, one response out.
module wb_master_cmd
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int GRANULE    = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  wb_master_cmd_if.master bus
);

  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;
  // A zero-width counter is illegal, so TIMEOUT=0 keeps a dummy 1-bit counter.
  localparam int CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  wb_master_state_t      state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  wb_rsp_status_t        rsp_status_q, rsp_status_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [SEL_WIDTH-1:0] sel);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < SEL_WIDTH; i++) m[i*GRANULE +: GRANULE] = {GRANULE{sel[i]}};
    return m;
  endfunction

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid_i && cmd_ready_q) begin
          state_d     = ST_ACTIVE;
          cmd_ready_d = 1'b0;
          cyc_d       = 1'b1;
          we_d        = bus.cmd_we_i;
          adr_d       = bus.cmd_adr_i;
          dat_d       = bus.cmd_dat_i;
          sel_d       = bus.cmd_sel_i;
          cnt_d       = '0;
        end
      end
      ST_ACTIVE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // err has priority over a simultaneous ack; a termination in the last
        // allowed cycle beats the timeout.
        if (bus.err_i) begin
          state_d      = ST_RESPOND;
          cyc_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = RSP_ERR;
          rsp_dat_d    = '0;
        end else if (bus.ack_i) begin
          state_d      = ST_RESPOND;
          cyc_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = RSP_OK;
          rsp_dat_d    = we_q ? '0 : (bus.dat_i & lane_mask(sel_q));
        end else if ((TIMEOUT != 0) && (int'(cnt_q) + 1 == TIMEOUT)) begin
          state_d      = ST_RESPOND;
          cyc_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = RSP_TIMEOUT;
          rsp_dat_d    = '0;
        end
      end
      ST_RESPOND: begin
        if (bus.rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= RSP_OK;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.cmd_ready_o  = cmd_ready_q;
  assign bus.cyc_o        = cyc_q;
  assign bus.stb_o        = cyc_q;
  assign bus.we_o         = we_q;
  assign bus.adr_o        = adr_q;
  assign bus.dat_o        = dat_q;
  assign bus.sel_o        = sel_q;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_dat_o    = rsp_dat_q;
  assign bus.rsp_status_o = rsp_status_q;

endmodule

// File: tb/tb_wb_master_cmd.sv
// Randomized scoreboard bench for wb_master_cmd with a behavioural slave and transaction model.
module tb_wb_master_cmd;
  import wb_pkg::*;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int G   = 8;
  localparam int TMO = 16;

  typedef struct {
    int          kind;  // 0 ack, 1 err, 2 ack+err, 3 silent
    int          lat;   // cycles after stb rises before termination
    logic [31:0] dat;
  } plan_t;

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    bit          chk_dur;
    int          dur;
  } bus_exp_t;

  typedef struct {
    logic [1:0]  status;
    logic [31:0] dat;
  } rsp_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst0 = 1'b1;
  always #5 clk = ~clk;

  wb_master_cmd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(G)) bus ();
  wb_master_cmd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(G)) bus0 ();

  wb_master_cmd #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(G), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.master));
  wb_master_cmd #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(G), .TIMEOUT(0)) dut0 (
    .clk_i(clk), .rst_i(rst0), .bus(bus0.master));

  plan_t    plan_q[$];
  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];
  int checks = 0;
  int failures = 0;
  int hold = 0;
  bit noise_en = 1'b1;
  bit dut0_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic plan_t mk_plan(input int k, input int l, input logic [31:0] d);
    plan_t p;
    p.kind = k;
    p.lat  = l;
    p.dat  = d;
    return p;
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 4; i++)
      if (s[i]) r = r | (d & (32'hFF << (8 * i)));
    return r;
  endfunction

  // Reference model: what the transaction must look like on the bus and in the response.
  task automatic issue(input logic we, input logic [15:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input plan_t p, input bit expect_rsp);
    bus_exp_t be;
    rsp_exp_t re;
    int waitc;
    if (p.kind == 3 || p.lat >= TMO) begin
      re.status = 2'd2; re.dat = 32'h0; be.dur = TMO;
    end else begin
      be.dur = p.lat + 1;
      if (p.kind != 0) begin re.status = 2'd1; re.dat = 32'h0; end
      else begin re.status = 2'd0; re.dat = we ? 32'h0 : lanes(p.dat, sel); end
    end
    be.we = we; be.adr = adr; be.dat = dat; be.sel = sel; be.chk_dur = expect_rsp;
    plan_q.push_back(p);
    bus_q.push_back(be);
    if (expect_rsp) rsp_q.push_back(re);
    bus.cmd_we_i = we; bus.cmd_adr_i = adr; bus.cmd_dat_i = dat; bus.cmd_sel_i = sel;
    bus.cmd_valid_i = 1'b1;
    waitc = 0;
    forever begin
      @(negedge clk);
      if (bus.cmd_ready_o) break;
      waitc++;
      if (waitc > 300) begin
        failures++;
        $display("FAIL cmd_accept_timeout actual=no_ready required=ready t=%0t", $time);
        $fatal(1, "command never accepted");
      end
    end
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_adr_i = 16'($urandom);
    bus.cmd_dat_i = $urandom;
    check("stb_cyc_latency1", {bus.cyc_o, bus.stb_o}, 2'b11);
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (rsp_q.size() != 0 && c < 500) begin @(posedge clk); c++; end
    repeat (2) @(posedge clk);
    #1;
    check("drain_rsp_queue", rsp_q.size(), 0);
  endtask

  // Behavioural slave: terminates per plan, random noise on ack/err while stb is low.
  initial begin : slave
    plan_t s_plan;
    int    s_cnt;
    bit    s_active;
    s_active = 1'b0; s_cnt = 0; s_plan = mk_plan(3, 0, 32'h0);
    bus.ack_i = 1'b0; bus.err_i = 1'b0; bus.dat_i = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (bus.stb_o) begin
        if (!s_active) begin
          s_active = 1'b1; s_cnt = 0;
          s_plan = (plan_q.size() > 0) ? plan_q.pop_front() : mk_plan(3, 0, 32'h0);
        end
        if (s_plan.kind != 3 && s_cnt == s_plan.lat) begin
          bus.ack_i = (s_plan.kind == 0 || s_plan.kind == 2);
          bus.err_i = (s_plan.kind == 1 || s_plan.kind == 2);
          bus.dat_i = s_plan.dat;
        end else begin
          bus.ack_i = 1'b0; bus.err_i = 1'b0; bus.dat_i = $urandom;
        end
        s_cnt++;
      end else begin
        s_active = 1'b0;
        bus.ack_i = noise_en && ($urandom_range(0, 3) == 0);
        bus.err_i = noise_en && ($urandom_range(0, 7) == 0);
        bus.dat_i = $urandom;
      end
    end
  end

  initial begin : rsp_ready_drv
    bus.rsp_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hold > 0) begin
        bus.rsp_ready_i = 1'b0;
        if (bus.rsp_valid_o) hold--;
      end else begin
        bus.rsp_ready_i = ($urandom_range(0, 2) != 0);
      end
    end
  end

  // Bus monitor: cycle contents, duration, stability and idle gap.
  initial begin : bus_mon
    bit          prev_cyc, have, unstable;
    int          run, low;
    bus_exp_t    cur;
    logic [15:0] s_adr;
    logic [31:0] s_dat;
    logic [3:0]  s_sel;
    logic        s_we;
    prev_cyc = 1'b0; have = 1'b0; unstable = 1'b0; run = 0; low = 99;
    forever begin
      @(negedge clk);
      if (bus.cyc_o) begin
        if (!prev_cyc) begin
          check("stb_idle_gap_ge2", (low >= 2), 1'b1);
          if (bus_q.size() == 0) begin
            check("unexpected_bus_cycle", 1'b1, 1'b0);
            have = 1'b0;
          end else begin
            cur = bus_q.pop_front();
            have = 1'b1;
            check("we_o", bus.we_o, cur.we);
            check("adr_o", bus.adr_o, cur.adr);
            check("dat_o", bus.dat_o, cur.dat);
            check("sel_o", bus.sel_o, cur.sel);
          end
          s_adr = bus.adr_o; s_dat = bus.dat_o; s_sel = bus.sel_o; s_we = bus.we_o;
          run = 0; unstable = 1'b0;
        end else if (bus.adr_o !== s_adr || bus.dat_o !== s_dat || bus.sel_o !== s_sel ||
                     bus.we_o !== s_we) begin
          unstable = 1'b1;
        end
        if (bus.stb_o !== 1'b1 || bus.cmd_ready_o !== 1'b0) unstable = 1'b1;
        run++;
      end else begin
        if (prev_cyc && have) begin
          if (cur.chk_dur) check("cyc_active_cycles", run, cur.dur);
          check("bus_stable_during_cycle", unstable, 1'b0);
          have = 1'b0;
        end
        if (bus.stb_o !== 1'b0) check("stb_without_cyc", bus.stb_o, 1'b0);
        low = prev_cyc ? 1 : low + 1;
      end
      prev_cyc = bus.cyc_o;
    end
  end

  // Response monitor: pops the scoreboard on each handshake.
  initial begin : rsp_mon
    bit          prev_valid, prev_hs;
    logic [31:0] s_dat;
    logic [1:0]  s_st;
    rsp_exp_t    e;
    prev_valid = 1'b0; prev_hs = 1'b0; s_dat = 32'h0; s_st = 2'd0;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid_o) begin
        check("cmd_ready_low_while_rsp", bus.cmd_ready_o, 1'b0);
        if (prev_valid && !prev_hs)
          check("rsp_stable", {bus.rsp_status_o, bus.rsp_dat_o}, {s_st, s_dat});
        if (bus.rsp_ready_i) begin
          if (rsp_q.size() == 0) begin
            check("unexpected_response", 1'b1, 1'b0);
          end else begin
            e = rsp_q.pop_front();
            check("rsp_status", bus.rsp_status_o, e.status);
            check("rsp_dat", bus.rsp_dat_o, e.dat);
          end
        end
      end
      prev_valid = bus.rsp_valid_o;
      prev_hs = bus.rsp_valid_o && bus.rsp_ready_i;
      s_dat = bus.rsp_dat_o;
      s_st = bus.rsp_status_o;
    end
  end

  // TIMEOUT=0 instance: a silent slave must leave the cycle open indefinitely.
  initial begin : no_timeout
    int hi, c;
    bus0.cmd_valid_i = 1'b0; bus0.cmd_we_i = 1'b0; bus0.cmd_adr_i = 16'h0001;
    bus0.cmd_dat_i = 32'h0; bus0.cmd_sel_i = 4'hF; bus0.rsp_ready_i = 1'b1;
    bus0.dat_i = 32'h0; bus0.ack_i = 1'b0; bus0.err_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst0 = 1'b0;
    bus0.cmd_valid_i = 1'b1;
    c = 0;
    forever begin
      @(negedge clk);
      if (bus0.cmd_ready_o || c > 20) break;
      c++;
    end
    check("t0_cmd_accepted", bus0.cmd_ready_o, 1'b1);
    @(posedge clk); #1;
    bus0.cmd_valid_i = 1'b0;
    hi = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus0.cyc_o && bus0.stb_o && !bus0.rsp_valid_o) hi++;
    end
    check("t0_cyc_high_1000", hi, 1000);
    @(posedge clk); #1 rst0 = 1'b1;
    @(posedge clk); #1;
    check("t0_reset_drops_cyc", bus0.cyc_o, 1'b0);
    rst0 = 1'b0;
    dut0_done = 1'b1;
  end

  initial begin : main
    int c;
    logic [3:0] sel;
    int k;
    bus.cmd_valid_i = 1'b0; bus.cmd_we_i = 1'b0; bus.cmd_adr_i = 16'h0;
    bus.cmd_dat_i = 32'h0; bus.cmd_sel_i = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", bus.cmd_ready_o, 1'b0);
    check("rst_cyc", bus.cyc_o, 1'b0);
    check("rst_stb", bus.stb_o, 1'b0);
    check("rst_we", bus.we_o, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
    check("rst_adr", bus.adr_o, 16'h0);
    check("rst_dat", bus.dat_o, 32'h0);
    check("rst_sel", bus.sel_o, 4'h0);
    check("rst_rsp_dat", bus.rsp_dat_o, 32'h0);
    check("rst_rsp_status", bus.rsp_status_o, 2'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", bus.cmd_ready_o, 1'b1);

    issue(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, mk_plan(0, 2, 32'hA5A5A5A5), 1'b1);
    issue(1'b0, 16'h0020, 32'h0, 4'b0011, mk_plan(0, 1, 32'h12345678), 1'b1);
    issue(1'b0, 16'h0030, 32'h0, 4'hF, mk_plan(2, 0, 32'hFFFFFFFF), 1'b1);
    issue(1'b0, 16'h0040, 32'h0, 4'hF, mk_plan(3, 0, 32'h0), 1'b1);
    issue(1'b0, 16'h0044, 32'h0, 4'b1100, mk_plan(0, 15, 32'hCAFEF00D), 1'b1);
    issue(1'b0, 16'h0048, 32'h0, 4'hF, mk_plan(0, 16, 32'h11111111), 1'b1);
    wait_drain();

    // Response held off while the next command is already waiting.
    hold = 5;
    issue(1'b0, 16'h0060, 32'h0, 4'b0101, mk_plan(0, 1, 32'h89ABCDEF), 1'b1);
    issue(1'b1, 16'h0064, 32'h01020304, 4'hF, mk_plan(0, 0, 32'h0), 1'b1);
    wait_drain();

    // Reset in the middle of an open cycle discards it.
    issue(1'b0, 16'h0050, 32'h0, 4'hF, mk_plan(3, 0, 32'h0), 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_cyc", bus.cyc_o, 1'b0);
    check("midrst_stb", bus.stb_o, 1'b0);
    check("midrst_rsp_valid", bus.rsp_valid_o, 1'b0);
    check("midrst_cmd_ready", bus.cmd_ready_o, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_ready_rises", bus.cmd_ready_o, 1'b1);
    issue(1'b0, 16'h0054, 32'h0, 4'hF, mk_plan(0, 3, 32'h55AA33CC), 1'b1);
    wait_drain();

    for (int n = 0; n < 40; n++) begin
      k = int'($urandom_range(0, 7));
      sel = 4'($urandom);
      if ($urandom_range(0, 9) == 0) hold = int'($urandom_range(1, 6));
      issue(1'($urandom), 16'($urandom), $urandom, sel,
            mk_plan((k <= 4) ? 0 : k - 4, int'($urandom_range(0, 19)), $urandom), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_drain();
    check("drain_bus_queue", bus_q.size(), 0);

    c = 0;
    while (!dut0_done && c < 3000) begin @(posedge clk); c++; end
    check("t0_sequence_done", dut0_done, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_master_cmd.md
WB_MASTER_CMD -- requirements
Module: wb_master_cmd

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: width of the Wishbone address and the command address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: port size in bits; legal values are 8, 16, 32 and 64.
REQ-003 SHALL have parameter GRANULE, default 8: port granularity in bits; SEL_WIDTH = DATA_WIDTH/GRANULE (localparam).
REQ-004 SHALL have parameter TIMEOUT, default 255: cycles to wait for a termination before aborting; 0 disables the timeout.
REQ-005 SHALL have one clock, clk_i, and a synchronous active-high reset, rst_i.
REQ-006 clk_i  in  1  sole clock; all logic on posedge.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 cmd_valid_i  in  1  command request.
REQ-009 cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
REQ-010 cmd_we_i  in  1  1 = write, 0 = read.
REQ-011 cmd_adr_i  in  ADDR_WIDTH  target address.
REQ-012 cmd_dat_i  in  DATA_WIDTH  write data.
REQ-013 cmd_sel_i  in  SEL_WIDTH  lane select.
REQ-014 rsp_valid_o  out  1  response available.
REQ-015 rsp_ready_i  in  1  response consumed.
REQ-016 rsp_dat_o  out  DATA_WIDTH  read data.
REQ-017 rsp_status_o  out  2  response status: 0 = OK, 1 = ERR, 2 = TIMEOUT.
REQ-018 adr_o, dat_o, sel_o, we_o, stb_o, cyc_o  out  ADDR_WIDTH, DATA_WIDTH, SEL_WIDTH, 1, 1, 1  Wishbone B4 classic master outputs.
REQ-019 dat_i, ack_i, err_i  in  DATA_WIDTH, 1, 1  Wishbone slave returns.

Function
REQ-020 SHALL implement FSM states IDLE, ACTIVE and RESPOND.
REQ-021 IDLE: cmd_ready_o=1; on cmd_valid_i&&cmd_ready_o, SHALL latch we/adr/dat/sel into the Wishbone output registers and enter ACTIVE.
REQ-022 ACTIVE: cyc_o=stb_o=1 starting the cycle after acceptance (latency 1); cmd_ready_o=0; Wishbone outputs held stable.
REQ-023 ACTIVE: on ack_i sampled high, SHALL capture dat_i on selected lanes (unselected lanes zero; all zero for writes), set status OK, drop cyc_o/stb_o at the next edge and enter RESPOND.
REQ-024 ACTIVE: on err_i sampled high, SHALL set status ERR with rsp_dat_o=0; if ack_i and err_i are high simultaneously, err_i wins.
REQ-025 ACTIVE: SHALL use a counter of width $clog2(TIMEOUT+1) that increments per ACTIVE cycle; when it reaches TIMEOUT with no termination (TIMEOUT>0), SHALL drop cyc/stb, set status TIMEOUT with data 0 and enter RESPOND; the counter is cleared on entry to ACTIVE.
REQ-026 RESPOND: rsp_valid_o=1 with rsp_dat_o/rsp_status_o stable until rsp_ready_i is sampled high, then SHALL go to IDLE; cyc_o=stb_o=0.
REQ-027 stb_o SHALL be low for at least 2 cycles between consecutive cycles (RESPOND + IDLE), so registered-ack slaves return to idle.
REQ-028 ack_i/err_i outside ACTIVE SHALL be ignored.
REQ-029 Back-to-back throughput: one transaction per termination latency + 3 cycles minimum.

Reset
REQ-030 While rst_i is high at a posedge: state=IDLE; cyc_o, stb_o, we_o, rsp_valid_o, cmd_ready_o=0; adr_o, dat_o, sel_o, rsp_dat_o, rsp_status_o, counter=0.
REQ-031 Reset mid-ACTIVE or mid-RESPOND SHALL drop cyc_o/stb_o at that edge and discard the pending response; cmd_ready_o rises the first cycle after rst_i falls.

Structure
REQ-032 Shared package wb_pkg SHALL hold wb_master_state_t (IDLE/ACTIVE/RESPOND) and wb_rsp_status_t (OK/ERR/TIMEOUT); no typedefs in $unit scope.
REQ-033 No sub-module; the timeout counter is inline.

Verification
REQ-034 Write of 0xDEADBEEF, adr 0x0010, sel 4'hF to a slave acking 2 cycles after stb -> cyc/stb/we_o high 1 cycle after accept, held 3 cycles; rsp status OK, rsp_dat_o 0.
REQ-035 Read with sel 4'b0011, slave returning 0x12345678 -> rsp_dat_o 0x00005678, status OK.
REQ-036 err_i and ack_i asserted together -> status ERR, rsp_dat_o 0, cyc_o low next edge.
REQ-037 TIMEOUT=16 with a silent slave -> cyc_o drops after exactly 16 ACTIVE cycles, status TIMEOUT; with TIMEOUT=0, cyc_o remains high for 1000 cycles.
REQ-038 rsp_ready_i held low 5 cycles with cmd_valid_i high -> rsp_valid_o and data stable, cmd_ready_o low, second command accepted only after the response handshake, with stb_o low for at least 2 cycles.
REQ-039 rst_i pulsed during ACTIVE -> cyc_o/stb_o 0 at that edge, no rsp_valid_o, next command completes normally.
